// File: rtl/s3g_rx.sv
// Receive-side S3G packet framer: hunts for 0xD5, then length, payload and CRC8,
// and holds the decoded packet until the command decoder acknowledges it.
module s3g_rx #(
    parameter int TIMEOUT = 100000,
    parameter int TO_W    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       packet_ack,
    output logic       packet_rdy,
    output logic       busy,
    output logic [7:0] payload_len,
    output logic [7:0] buf0,
    output logic [7:0] buf1,
    output logic [7:0] buf2,
    output logic [7:0] buf3,
    output logic [7:0] buf4,
    output logic [7:0] buf5,
    output logic [7:0] buf6,
    output logic [7:0] buf7,
    output logic [7:0] buf8,
    output logic [7:0] buf9,
    output logic [7:0] buf10,
    output logic [7:0] buf11,
    output logic [7:0] buf12,
    output logic [7:0] buf13,
    output logic [7:0] buf14,
    output logic [7:0] buf15,
    output logic       crc_err,
    output logic       len_err,
    output logic       timeout,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CRC  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    localparam logic [7:0]      SYNC_BYTE = 8'hD5;
    localparam logic [7:0]      MAX_LEN   = 8'd16;
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);

    state_t          r_state;
    state_t          w_nextState;
    logic [7:0]      r_len;
    logic [7:0]      r_crc;
    logic [3:0]      r_byteCnt;
    logic [7:0]      r_buf [16];
    logic [TO_W-1:0] r_toCnt;
    logic            r_crcErr;
    logic            r_lenErr;
    logic            r_timeout;
    logic            r_overrun;

    logic            w_crcErr;
    logic            w_lenErr;
    logic            w_timeout;
    logic            w_overrun;
    logic            w_toExpired;
    logic            w_lastByte;
    logic [3:0]      w_lastIdx;
    logic [7:0]      w_crcNext;

    // CRC8, polynomial x^8+x^2+x+1, data shifted in MSB first.
    function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data, input logic [7:0] crc);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ data[i];
            c  = {c[6:0], 1'b0};
            if (fb) begin
                c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // A length of 16 wraps to index 15 in the 4-bit counter domain.
    assign w_lastIdx   = r_len[3:0] - 4'd1;
    assign w_lastByte  = (r_byteCnt == w_lastIdx);
    assign w_crcNext   = nextCRC8_D8(rx_data, r_crc);
    assign w_toExpired = (TIMEOUT != 0) && (r_toCnt == TO_LIMIT);

    always_comb begin
        w_nextState = r_state;
        w_crcErr    = 1'b0;
        w_lenErr    = 1'b0;
        w_timeout   = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_done && (rx_data == SYNC_BYTE)) begin
                    w_nextState = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_done) begin
                    if (rx_data > MAX_LEN) begin
                        w_lenErr    = 1'b1;
                        w_nextState = S_IDLE;
                    end else if (rx_data == 8'd0) begin
                        w_nextState = S_CRC;
                    end else begin
                        w_nextState = S_DATA;
                    end
                end else if (w_toExpired) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_done) begin
                    if (w_lastByte) begin
                        w_nextState = S_CRC;
                    end
                end else if (w_toExpired) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            S_CRC: begin
                if (rx_done) begin
                    if (rx_data == r_crc) begin
                        w_nextState = S_HOLD;
                    end else begin
                        w_crcErr    = 1'b1;
                        w_nextState = S_IDLE;
                    end
                end else if (w_toExpired) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            S_HOLD: begin
                // A held packet is never overwritten; any byte arriving now is lost.
                w_overrun = rx_done;
                if (packet_ack) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= 8'd0;
            r_crc     <= 8'd0;
            r_byteCnt <= 4'd0;
            r_toCnt   <= '0;
            r_crcErr  <= 1'b0;
            r_lenErr  <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= 8'd0;
            end
        end else begin
            r_state   <= w_nextState;
            r_crcErr  <= w_crcErr;
            r_lenErr  <= w_lenErr;
            r_timeout <= w_timeout;
            r_overrun <= w_overrun;

            if ((r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CRC)) begin
                r_toCnt <= rx_done ? '0 : r_toCnt + 1'b1;
            end else begin
                r_toCnt <= '0;
            end

            if ((r_state == S_LEN) && rx_done && (rx_data <= MAX_LEN)) begin
                r_len     <= rx_data;
                r_crc     <= 8'd0;
                r_byteCnt <= 4'd0;
                for (int i = 0; i < 16; i++) begin
                    r_buf[i] <= 8'd0;
                end
            end

            if ((r_state == S_DATA) && rx_done) begin
                r_buf[r_byteCnt] <= rx_data;
                r_crc            <= w_crcNext;
                r_byteCnt        <= r_byteCnt + 4'd1;
            end
        end
    end

    assign packet_rdy  = (r_state == S_HOLD);
    assign busy        = (r_state != S_IDLE);
    assign payload_len = r_len;
    assign crc_err     = r_crcErr;
    assign len_err     = r_lenErr;
    assign timeout     = r_timeout;
    assign overrun     = r_overrun;

    assign buf0  = r_buf[0];
    assign buf1  = r_buf[1];
    assign buf2  = r_buf[2];
    assign buf3  = r_buf[3];
    assign buf4  = r_buf[4];
    assign buf5  = r_buf[5];
    assign buf6  = r_buf[6];
    assign buf7  = r_buf[7];
    assign buf8  = r_buf[8];
    assign buf9  = r_buf[9];
    assign buf10 = r_buf[10];
    assign buf11 = r_buf[11];
    assign buf12 = r_buf[12];
    assign buf13 = r_buf[13];
    assign buf14 = r_buf[14];
    assign buf15 = r_buf[15];

endmodule
